// File: rtl/mdu_iterative.sv
// mdu_iterative: multiply/divide unit for the EX stage.
//   Signed/unsigned multiply (single registered cycle when FAST_MUL=1, else
//   radix-2 shift-add) and signed/unsigned restoring divide, WIDTH-bit operands,
//   2*WIDTH result as hi/lo.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, op         request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU), sampled on accept
//   srca, srcb        multiplicand/dividend, multiplier/divisor
//   cancel            abort in-flight operation; also blocks start
//   busy, done        stall indicator, one-cycle completion pulse
//   result_hi/lo      product high/low, or remainder/quotient
//   div_by_zero       set by a divide-by-zero completion, cleared by any other
module mdu_iterative #(
  parameter int WIDTH    = 32,
  parameter bit FAST_MUL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic               dz_q, dz_d;

  logic               sa, sb, accept, last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod, prod, prod_fix;
  logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
  logic [CW-1:0]      cnt_inc;

  always_comb begin
    sa     = ~op[0] & srca[WIDTH-1];
    sb     = ~op[0] & srcb[WIDTH-1];
    mag_a  = sa ? -srca : srca;
    mag_b  = sb ? -srcb : srcb;
    // Extending to 2W before multiplying yields the correct low 2W bits for
    // both signed and unsigned operands.
    ext_a  = op[0] ? {{WIDTH{1'b0}}, srca} : {{WIDTH{srca[WIDTH-1]}}, srca};
    ext_b  = op[0] ? {{WIDTH{1'b0}}, srcb} : {{WIDTH{srcb[WIDTH-1]}}, srcb};
    fast_prod = ext_a * ext_b;
    accept = start & ~cancel & ((state_q == S_IDLE) || (state_q == S_DONE));
    cnt_inc = cnt_q + CW'(1);
    last    = (cnt_inc == CW'(WIDTH));
    // Shift-add step: acc_lo holds the remaining multiplier bits.
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
    // Restoring step: acc_hi is the partial remainder, acc_lo shifts the
    // dividend out and the quotient in. div_diff[WIDTH] set means tmp < divisor.
    div_tmp  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff = div_tmp - {1'b0, b_q};
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d   = op;
          neg_d  = sa ^ sb;
          rneg_d = sa;
          cnt_d  = '0;
          if (!op[1]) begin
            if (FAST_MUL) begin
              state_d  = S_DONE;
              res_hi_d = fast_prod[2*WIDTH-1:WIDTH];
              res_lo_d = fast_prod[WIDTH-1:0];
              dz_d     = 1'b0;
            end else begin
              state_d  = S_MUL;
              b_d      = mag_a;
              acc_hi_d = '0;
              acc_lo_d = mag_b;
            end
          end else if (srcb == '0) begin
            state_d  = S_DONE;
            res_hi_d = srca;
            res_lo_d = '1;
            dz_d     = 1'b1;
          end else begin
            state_d  = S_DIV;
            b_d      = mag_b;
            acc_hi_d = '0;
            acc_lo_d = mag_a;
          end
        end
      end
      S_MUL: begin
        if (cancel) state_d = S_IDLE;
        else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          cnt_d    = cnt_inc;
          if (last) state_d = S_FIX;
        end
      end
      S_DIV: begin
        if (cancel) state_d = S_IDLE;
        else begin
          if (!div_diff[WIDTH]) acc_hi_d = div_diff[WIDTH-1:0];
          else                  acc_hi_d = div_tmp[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
          cnt_d    = cnt_inc;
          if (last) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (cancel) state_d = S_IDLE;
        else begin
          state_d = S_DONE;
          dz_d    = 1'b0;
          if (!op_q[1]) begin
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            res_lo_d = prod_fix[WIDTH-1:0];
          end else begin
            res_hi_d = rneg_q ? -acc_hi_q : acc_hi_q;
            res_lo_d = neg_q  ? -acc_lo_q : acc_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      b_q      <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      dz_q     <= dz_d;
    end
  end

  assign busy        = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign result_hi   = res_hi_q;
  assign result_lo   = res_lo_q;
  assign div_by_zero = dz_q;

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Parametrised multiply/divide unit for the EX stage; successor to the single-cycle combinational multiply inside the ALU.
- Executes signed and unsigned multiply, and signed and unsigned divide, on WIDTH-bit operands.
- Produces a 2*WIDTH result split as hi/lo for the HI/LO register file.
- Uses a start/busy/done handshake so the pipeline can stall during divide; supports cancel for exception flush.

Parameters:
- WIDTH, 32, operand width. Must be even and at least 4.
- FAST_MUL, 1:
  - 1: multiply completes in a single registered cycle.
  - 0: radix-2 shift-add multiply over WIDTH iterations.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; accepted only when busy=0
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- srca  input  WIDTH  multiplicand / dividend; sampled with start
- srcb  input  WIDTH  multiplier / divisor; sampled with start
- cancel  input  1  abort the in-flight operation (exception/flush)
- busy  output  1  operation in flight; the pipeline stalls on it
- done  output  1  one-cycle pulse; result valid
- result_hi  output  WIDTH  product high half, or remainder
- result_lo  output  WIDTH  product low half, or quotient
- div_by_zero  output  1  sticky flag for the last completed operation

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - busy=0, done=0, div_by_zero=0.
  - result_hi=0, result_lo=0.
  - Iteration counter and internal registers cleared.
  - A reset mid-operation discards all work.
- States:
  - IDLE: no operation in flight.
  - MUL: iterative multiply.
  - DIV: iterative divide.
  - FIX: sign correction.
  - DONE: result presented.
- Acceptance:
  - start is accepted in IDLE or DONE when cancel=0; call the accepting edge T0.
  - At T0: latch op; convert signed operands (MULT/DIV) to magnitudes and record the signs; clear the counter.
  - start while busy=1 is ignored and has no side effects.
- busy is 1 in MUL, DIV and FIX. It is 0 in IDLE and DONE.
- Multiply, FAST_MUL=1:
  - At T0+1: state=DONE, done=1.
  - result = signed or unsigned full product; no FIX cycle needed.
- Multiply, FAST_MUL=0:
  - MUL runs WIDTH iterations (edges T0+1..T0+WIDTH), then FIX at T0+WIDTH+1.
  - FIX negates the 2W product when the operand signs differ.
  - DONE (done=1) follows FIX: done is visible in the cycle after edge T0+WIDTH+1.
- Divide:
  - Restoring algorithm, one quotient bit per cycle, WIDTH iterations, then FIX.
  - Quotient sign = sign(srca) XOR sign(srcb); remainder sign = sign(srca).
  - Latency matches iterative multiply: done is visible in the cycle after edge T0+WIDTH+1.
  - Signed overflow: DIV of minimum-negative by -1 gives lo = minimum-negative (e.g. 0x80000000), hi=0, with no flag.
- Divide by zero (srcb=0, DIV or DIVU):
  - No iteration; state=DONE at T0+1.
  - lo = all ones, hi = srca (unmodified), div_by_zero=1.
- div_by_zero:
  - Updated at every completion: 1 for divide by zero, else 0.
  - Cleared by reset.
- done:
  - High for exactly the one cycle spent in DONE.
  - From DONE the unit returns to IDLE, or, if start is accepted during DONE, goes directly to the new op with done=0 on the next cycle.
- result_hi/result_lo:
  - Written only on entry to DONE.
  - Held stable until the next completion, including across cancel.
- Cancel:
  - In MUL, DIV or FIX: next state IDLE, busy=0 on the next cycle, no done, results and flag unchanged.
  - cancel with start in the same cycle: cancel wins and start is not accepted.
  - cancel in IDLE or DONE: no effect except blocking start.
- Counter: log2(WIDTH)+1 bits, with no wrap. Iteration ends when the count reaches WIDTH.

Test Plan:
- WIDTH=32, FAST_MUL=1, MULT srca=0xFFFFFFFD (-3), srcb=5 -> done at T0+1, hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy never 1.
- FAST_MUL=0, MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles, done once, hi=0xFFFFFFFE, lo=0x00000001.
- DIV srca=0xFFFFFFF9 (-7), srcb=2 -> done after 33 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU srca=0x12345678, srcb=0 -> done at T0+1, lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1; a following MULTU 2x3 clears the flag (lo=6).
- DIVU 100/7 started, cancel at cycle 10 -> busy=0 next cycle, no done, hi/lo retain the prior values. A start held during busy is ignored; a start issued afterwards gives lo=14, hi=2.
- Assert rst mid-DIV at cycle 5 -> all outputs 0 immediately (asynchronously). Back-to-back: start issued in the DONE cycle is accepted, and done pulses once per operation.
